// File: rtl/score_counter.sv
// score_counter: synchronised point counter with BCD/hex digits, saturation, win flag and clear
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   point      raw asynchronous point level, one point per rising edge
//   clear      synchronous clear of score and win
//   digits     4 bits per digit, [3:0] least significant
//   win        sticky, set when the score reaches WIN_SCORE (0 disables)
//   point_ack  one-cycle pulse per accepted increment
//   penalty    asynchronous penalty level, only with SCORE_PENALTY_EN defined
module score_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int DECIMAL    = 1,
  parameter int WIN_SCORE  = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    point,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    win,
  output logic                    point_ack
`ifdef SCORE_PENALTY_EN
  ,
  input  logic                    penalty
`endif
);
  localparam int D = 4 * NUM_DIGITS;
  localparam int RADIX = DECIMAL != 0 ? 10 : 16;
  localparam logic [3:0] TOP = DECIMAL != 0 ? 4'd9 : 4'd15;
  function automatic logic [D-1:0] win_code();
    int v = WIN_SCORE;
    logic [D-1:0] c = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      c[4*k+:4] = 4'(v % RADIX);
      v = v / RADIX;
    end
    return c;
  endfunction
  localparam logic [D-1:0] WIN_CODE = win_code();
  logic s0, s1, prev, inc_req, inc_go, cy;
  logic [D-1:0] inc_val;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {prev, s1, s0} <= '0;
    else {prev, s1, s0} <= {s1, s0, point};
  assign inc_req = s1 & ~prev;
`ifdef SCORE_PENALTY_EN
  logic p0, p1, pprev, dec_req, dec_go, bw;
  logic [D-1:0] dec_val;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {pprev, p1, p0} <= '0;
    else {pprev, p1, p0} <= {p1, p0, penalty};
  assign dec_req = p1 & ~pprev;
  always_comb begin
    dec_val = digits;
    bw = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dec_val[4*k+:4] = bw ? (digits[4*k+:4] == 4'd0 ? TOP : digits[4*k+:4] - 4'd1) : digits[4*k+:4];
      bw = bw & (digits[4*k+:4] == 4'd0);
    end
  end
  // bw ends high only when every digit is 0, i.e. at the floor
  assign inc_go = inc_req & ~dec_req & ~cy & ~win;
  assign dec_go = dec_req & ~inc_req & ~bw & ~win;
`else
  assign inc_go = inc_req & ~cy & ~win;
`endif
  // cy ends high only when every digit is at TOP, i.e. saturated
  always_comb begin
    inc_val = digits;
    cy = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      inc_val[4*k+:4] = cy ? (digits[4*k+:4] == TOP ? 4'd0 : digits[4*k+:4] + 4'd1) : digits[4*k+:4];
      cy = cy & (digits[4*k+:4] == TOP);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      digits <= '0;
      win <= 1'b0;
      point_ack <= 1'b0;
    end else begin
      point_ack <= inc_go & ~clear;
      if (clear) begin
        digits <= '0;
        win <= 1'b0;
      end else if (inc_go) begin
        digits <= inc_val;
        win <= (WIN_SCORE != 0) && (inc_val == WIN_CODE);
      end
`ifdef SCORE_PENALTY_EN
      else if (dec_go) digits <= dec_val;
`endif
    end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: scoreboard bench driving three score_counter configurations with shared stimulus
module tb_score_counter;
  logic clk = 0, reset_n = 0, point = 0, clear = 0;
`ifdef SCORE_PENALTY_EN
  logic penalty = 0;
`endif
  always #5 clk = ~clk;
  logic [7:0] dg[3];
  logic ack[3], wn[3];
  int rad[3] = '{10, 16, 10};
  int ws[3] = '{0, 0, 7};
  int sc[3] = '{0, 0, 0};
  bit w[3] = '{0, 0, 0};
  typedef struct {logic [7:0] d; logic w; int cyc;} exp_t;
  exp_t q[3][$];
  int cyc = 0, checks = 0, passes = 0;
  score_counter #(.NUM_DIGITS(2), .DECIMAL(1), .WIN_SCORE(0)) ua (.clk(clk), .reset_n(reset_n), .point(point), .clear(clear),
    .digits(dg[0]), .win(wn[0]), .point_ack(ack[0])
`ifdef SCORE_PENALTY_EN
    , .penalty(penalty)
`endif
  );
  score_counter #(.NUM_DIGITS(2), .DECIMAL(0), .WIN_SCORE(0)) ub (.clk(clk), .reset_n(reset_n), .point(point), .clear(clear),
    .digits(dg[1]), .win(wn[1]), .point_ack(ack[1])
`ifdef SCORE_PENALTY_EN
    , .penalty(penalty)
`endif
  );
  score_counter #(.NUM_DIGITS(2), .DECIMAL(1), .WIN_SCORE(7)) uc (.clk(clk), .reset_n(reset_n), .point(point), .clear(clear),
    .digits(dg[2]), .win(wn[2]), .point_ack(ack[2])
`ifdef SCORE_PENALTY_EN
    , .penalty(penalty)
`endif
  );
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] td(int s, int r);
    return 8'((s / r) * 16 + s % r);
  endfunction
  task automatic chk(string n, int a, int e);
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      if (ack[i]) begin
        exp_t e;
        chk($sformatf("ack_expected%0d", i), int'(q[i].size() > 0), 1);
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          chk($sformatf("ack_digits%0d", i), dg[i], e.d);
          chk($sformatf("ack_win%0d", i), wn[i], e.w);
          chk($sformatf("ack_latency%0d", i), cyc, e.cyc);
        end
      end
  end
  task automatic rise_event();
    for (int i = 0; i < 3; i++)
      if (!w[i] && sc[i] < rad[i] * rad[i] - 1) begin
        sc[i]++;
        if (ws[i] != 0 && sc[i] == ws[i]) w[i] = 1;
        q[i].push_back('{td(sc[i], rad[i]), w[i], cyc + 3});
      end
  endtask
  task automatic pulse(int h, int l);
    point = 1;
    rise_event();
    repeat (h) @(negedge clk);
    point = 0;
    repeat (l) @(negedge clk);
  endtask
  task automatic check_all(string n);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_digits%0d", n, i), dg[i], td(sc[i], rad[i]));
      chk($sformatf("%s_win%0d", n, i), wn[i], w[i]);
      chk($sformatf("%s_pending%0d", n, i), q[i].size(), 0);
    end
  endtask
  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      sc[i] = 0;
      w[i] = 0;
    end
  endtask
  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
    model_zero();
  endtask
`ifdef SCORE_PENALTY_EN
  task automatic pen(bit with_point);
    penalty = 1;
    point = with_point;
    if (!with_point)
      for (int i = 0; i < 3; i++)
        if (!w[i] && sc[i] > 0) sc[i]--;
    repeat (2) @(negedge clk);
    penalty = 0;
    point = 0;
    repeat (2) @(negedge clk);
  endtask
`endif
  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_digits%0d", i), dg[i], 0);
      chk($sformatf("reset_win%0d", i), wn[i], 0);
      chk($sformatf("reset_ack%0d", i), ack[i], 0);
    end
    reset_n = 1;
    @(negedge clk);
    repeat (3) pulse(4, 4);
    check_all("three");
    repeat (6) pulse(4, 4);
    check_all("nine");
    pulse(4, 4);
    check_all("bcd_carry");
    repeat (5) pulse(3, 3);
    check_all("fifteen");
    pulse(3, 3);
    check_all("hex_carry");
    do_clear();
    check_all("clear");
    repeat (270) pulse($urandom_range(1, 5), $urandom_range(1, 5));
    check_all("rand_sat");
    repeat (2) pulse(4, 4);
    check_all("sat_hold");
    do_clear();
    pulse(50, 4);
    check_all("held");
    do_clear();
    point = 1;
    repeat (2) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    for (int i = 0; i < 3; i++) chk($sformatf("clr_inc_ack%0d", i), ack[i], 0);
    point = 0;
    model_zero();
    repeat (2) @(negedge clk);
    check_all("clr_inc");
    repeat (8) pulse(2, 2);
    check_all("pre_reset");
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_digits%0d", i), dg[i], 0);
      chk($sformatf("async_win%0d", i), wn[i], 0);
      chk($sformatf("async_ack%0d", i), ack[i], 0);
    end
    model_zero();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    pulse(2, 2);
    check_all("post_reset");
`ifdef SCORE_PENALTY_EN
    do_clear();
    repeat (10) pulse(2, 2);
    check_all("pen_pre");
    pen(0);
    check_all("pen_borrow");
    do_clear();
    pen(0);
    check_all("pen_floor");
    repeat (5) pulse(2, 2);
    check_all("pen_five");
    pen(1);
    check_all("pen_cancel");
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
